dense_seq_ctrl: RTL



---
 rtl/dense_seq_ctrl_pkg.sv | 37 +++
 rtl/dense_seq_ctrl_if.sv | 36 +++
 rtl/dense_seq_ctrl_relu.sv | 46 ++++
 rtl/dense_seq_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/dense_seq_ctrl_pkg.sv
// dense_pkg: shared constants and types for the dense classification sequencer.
// No ports. Holds the layer geometry (N_IN features, N_OUT neurons), the word,
// accumulator and score widths, the offset of the bias word inside each
// neuron's weight block, the FSM state encoding and the score type used by
// dense_seq_ctrl and dense_relu_q.
package dense_pkg;

    localparam int N_IN     = 144;
    localparam int N_OUT    = 4;
    localparam int DWIDTH   = 35;
    localparam int AWIDTH   = 73;
    localparam int RWIDTH   = 17;
    localparam int PWIDTH   = 2 * DWIDTH;

    // Word index of the bias inside one neuron's block of the weight ROM.
    localparam int BIAS_OFS = N_IN;
    // Stride between neuron blocks in the weight ROM (weights plus bias).
    localparam int W_STRIDE = N_IN + 1;

    localparam int FA_W     = 8;
    localparam int WA_W     = 10;
    localparam int IDX_W    = 2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_DRAIN  = 3'd2,
        S_POST   = 3'd3,
        S_ARGMAX = 3'd4,
        S_DONE   = 3'd5
    } state_e;

    typedef logic signed [DWIDTH-1:0] word_t;
    typedef logic signed [AWIDTH-1:0] acc_t;
    typedef logic signed [RWIDTH-1:0] score_t;

endpackage

// File: rtl/dense_seq_ctrl_if.sv
// dense_seq_ctrl_if: handshake and memory-read bus of the dense sequencer.
// Signals:
//   start      request pulse into the sequencer
//   busy       sequencer is running a classification
//   feat_addr  feature buffer read address
//   feat_data  feature word returned by the buffer
//   w_addr     weight ROM read address
//   w_data     weight/bias word returned by the ROM
//   done       one-cycle completion pulse
//   max_idx    winning class
//   changed    winning class differs from the previous result
// Modports: master = sequencer side, slave = feature buffer / ROM / host side.
interface dense_seq_ctrl_if;
    import dense_pkg::*;

    logic             start;
    logic             busy;
    logic [FA_W-1:0]  feat_addr;
    word_t            feat_data;
    logic [WA_W-1:0]  w_addr;
    word_t            w_data;
    logic             done;
    logic [IDX_W-1:0] max_idx;
    logic             changed;

    modport master (
        input  start, feat_data, w_data,
        output busy, feat_addr, w_addr, done, max_idx, changed
    );

    modport slave (
        output start, feat_data, w_data,
        input  busy, feat_addr, w_addr, done, max_idx, changed
    );

endinterface

// File: rtl/dense_seq_ctrl_relu.sv
// dense_relu_q: combinational bias subtract, ReLU and requantisation of one
// neuron's accumulator into a non-negative score.
// Parameters: SHIFT  right shift from accumulator to score, also the left
//                    shift applied to the bias word.
// Ports:
//   acc    in   signed accumulator (sum of feature*weight products)
//   bias   in   signed bias word for this neuron
//   score  out  ReLU score, MSB always 0
// Build option: DENSE_SAT_EN defined -> oversized positive results clip to the
// largest score; undefined -> the score keeps the low RWIDTH-1 bits (wraps).
module dense_relu_q
    import dense_pkg::*;
#(
    parameter int SHIFT = 56
) (
    input  acc_t   acc,
    input  word_t  bias,
    output score_t score
);

    // One guard bit above the wider of the accumulator and the shifted bias
    // keeps the subtraction free of overflow.
    localparam int VW = ((AWIDTH > DWIDTH + SHIFT) ? AWIDTH : (DWIDTH + SHIFT)) + 1;
    localparam logic [VW-1:0] RMAX = VW'((64'd1 << (RWIDTH - 1)) - 64'd1);

    logic signed [VW-1:0] acc_x;
    logic signed [VW-1:0] bias_x;
    logic signed [VW-1:0] v;
    logic [VW-1:0]        mag;

    always_comb begin
        acc_x  = {{(VW - AWIDTH){acc[AWIDTH-1]}}, acc};
        bias_x = {{(VW - DWIDTH){bias[DWIDTH-1]}}, bias} << SHIFT;
        v      = acc_x - bias_x;
        mag    = $unsigned(v) >> SHIFT;
        score  = '0;
        if (!v[VW-1]) begin
`ifdef DENSE_SAT_EN
            score = (mag > RMAX) ? score_t'(RMAX) : score_t'(mag);
`else
            score = score_t'(mag & RMAX);
`endif
        end
    end

endmodule

// File: rtl/dense_seq_ctrl.sv
// dense_seq_ctrl: time-multiplexed sequencer for the final dense layer.
// A single signed MAC walks N_IN features for each of N_OUT neurons, subtracts
// the bias, applies ReLU/requantisation, then reports the argmax class.
// Parameters:
//   SHIFT     accumulator-to-score right shift (and bias left shift)
//   READ_LAT  address-to-data latency of both memories, 1..3
// Ports:
//   clk    in  clock
//   reset  in  asynchronous active-low reset
//   bus    master side of dense_seq_ctrl_if (start/busy/done/max_idx/changed
//          handshake plus feature buffer and weight ROM read ports)
// Build option: DENSE_SAT_EN selects score saturation instead of wrap
// (implemented in dense_relu_q).
module dense_seq_ctrl
    import dense_pkg::*;
#(
    parameter int SHIFT    = 56,
    parameter int READ_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    dense_seq_ctrl_if.master bus
);

    localparam logic [FA_W-1:0]  I_LAST = FA_W'(BIAS_OFS);
    localparam logic [IDX_W-1:0] N_LAST = IDX_W'(N_OUT - 1);

    state_e                   state;
    logic [IDX_W-1:0]         n;
    logic [FA_W-1:0]          i;
    logic [1:0]               drain_cnt;

    logic                     busy_q;
    logic                     done_q;
    logic                     changed_q;
    logic [IDX_W-1:0]         max_idx_q;
    logic [IDX_W-1:0]         prev_idx;
    logic [IDX_W-1:0]         best_idx;
    logic [IDX_W-1:0]         best_c;

    logic [READ_LAT-1:0]      feat_tag;
    logic [READ_LAT-1:0]      bias_tag;

    logic signed [PWIDTH-1:0] feat_x;
    logic signed [PWIDTH-1:0] wgt_x;
    logic signed [PWIDTH-1:0] prod_c;
    logic signed [PWIDTH-1:0] prod_q;
    logic                     prod_v;
    acc_t                     acc;
    word_t                    bias_q;

    score_t                   score [N_OUT];
    score_t                   relu_out;

    logic [FA_W-1:0]          feat_addr_c;
    logic [WA_W-1:0]          w_addr_c;
    logic                     accept;
    logic                     issuing;

    assign accept  = (state == S_IDLE) && bus.start;
    assign issuing = (state == S_ISSUE);

    // Addresses follow the issue counter directly; the bias slot (i == N_IN)
    // leaves the feature address at 0 since that read is not used.
    always_comb begin
        feat_addr_c = '0;
        w_addr_c    = '0;
        if (issuing) begin
            if (i != I_LAST) begin
                feat_addr_c = i;
            end
            w_addr_c = WA_W'(n) * WA_W'(W_STRIDE) + WA_W'(i);
        end
    end

    // Tags travel alongside the reads so the datapath knows, READ_LAT cycles
    // later, whether the returning words are a feature/weight pair or the bias.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            feat_tag <= '0;
            bias_tag <= '0;
        end else begin
            feat_tag[0] <= issuing && (i != I_LAST);
            bias_tag[0] <= issuing && (i == I_LAST);
            for (int k = 1; k < READ_LAT; k++) begin
                feat_tag[k] <= feat_tag[k-1];
                bias_tag[k] <= bias_tag[k-1];
            end
        end
    end

    assign feat_x = {{DWIDTH{bus.feat_data[DWIDTH-1]}}, bus.feat_data};
    assign wgt_x  = {{DWIDTH{bus.w_data[DWIDTH-1]}}, bus.w_data};
    assign prod_c = feat_x * wgt_x;

    // Product is registered before accumulation to keep the multiplier and
    // the wide adder in separate cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prod_q <= '0;
            prod_v <= 1'b0;
            bias_q <= '0;
            acc    <= '0;
        end else begin
            prod_v <= feat_tag[READ_LAT-1];
            if (feat_tag[READ_LAT-1]) begin
                prod_q <= prod_c;
            end
            if (bias_tag[READ_LAT-1]) begin
                bias_q <= bus.w_data;
            end
            if (accept || (state == S_POST)) begin
                acc <= '0;
            end else if (prod_v) begin
                acc <= acc + {{(AWIDTH - PWIDTH){prod_q[PWIDTH-1]}}, prod_q};
            end
        end
    end

    dense_relu_q #(
        .SHIFT (SHIFT)
    ) u_relu (
        .acc   (acc),
        .bias  (bias_q),
        .score (relu_out)
    );

    // Strict greater-than scan so ties keep the lowest index.
    always_comb begin
        best_c = '0;
        for (int k = 1; k < N_OUT; k++) begin
            if (score[k] > score[best_c]) begin
                best_c = IDX_W'(k);
            end
        end
    end

    // Main sequencer. DRAIN counts READ_LAT down to 0, giving READ_LAT+1
    // cycles for the last product and the bias to land in their registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            n         <= '0;
            i         <= '0;
            drain_cnt <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            changed_q <= 1'b0;
            max_idx_q <= '0;
            prev_idx  <= '0;
            best_idx  <= '0;
            for (int k = 0; k < N_OUT; k++) begin
                score[k] <= '0;
            end
        end else begin
            done_q    <= 1'b0;
            changed_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        n      <= '0;
                        i      <= '0;
                        busy_q <= 1'b1;
                        state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (i == I_LAST) begin
                        drain_cnt <= 2'(READ_LAT);
                        state     <= S_DRAIN;
                    end else begin
                        i <= i + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == 2'd0) begin
                        state <= S_POST;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                S_POST: begin
                    score[n] <= relu_out;
                    if (n == N_LAST) begin
                        state <= S_ARGMAX;
                    end else begin
                        n     <= n + 1'b1;
                        i     <= '0;
                        state <= S_ISSUE;
                    end
                end
                S_ARGMAX: begin
                    best_idx <= best_c;
                    state    <= S_DONE;
                end
                S_DONE: begin
                    done_q    <= 1'b1;
                    max_idx_q <= best_idx;
                    changed_q <= (best_idx != prev_idx);
                    prev_idx  <= best_idx;
                    busy_q    <= 1'b0;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.changed   = changed_q;
    assign bus.max_idx   = max_idx_q;
    assign bus.feat_addr = feat_addr_c;
    assign bus.w_addr    = w_addr_c;

endmodule
